// File: rtl/fb_dac_driver_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_dac_pkg : shared types, widths and helpers for the kicker DAC driver  |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
package fb_dac_pkg;

    localparam int DAC_W     = 14;
    localparam int GAIN_FRAC = 6;
    localparam int POS_W     = 15;
    localparam int ACC_W     = 16;
    localparam int PROD_W    = 24;
    localparam int SUM_W     = 19;

    localparam logic [DAC_W-1:0] DAC_MID = {1'b1, {(DAC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACC1  = 3'd1,
        ST_SCALE = 3'd2,
        ST_READY = 3'd3,
        ST_WRITE = 3'd4
    } state_e;

    // Two's complement to offset-binary: only the sign bit flips.
    function automatic logic [DAC_W-1:0] to_offset_binary(input logic signed [DAC_W-1:0] v);
        return {~v[DAC_W-1], v[DAC_W-2:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_dac_driver_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_dac_driver_if : DSP-side inputs, control and DAC-side outputs         |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
interface fb_dac_driver_if #(
    parameter int DAC_W = 14
);
    logic signed [14:0]      pout;
    logic                    dsp_oflow;
    logic                    fb_cond;
    logic                    dac_clk_in;
    logic                    fb_en;
    logic                    store_strb;
    logic [7:0]              gain;
    logic signed [DAC_W-1:0] offset;
    logic [DAC_W-2:0]        out_lim;
    logic [DAC_W-1:0]        dac_data;
    logic                    dac_wr;
    logic                    sat_flag;
    logic [7:0]              oflow_count;

    modport master (
        output pout, dsp_oflow, fb_cond, dac_clk_in, fb_en, store_strb,
               gain, offset, out_lim,
        input  dac_data, dac_wr, sat_flag, oflow_count
    );

    modport slave (
        input  pout, dsp_oflow, fb_cond, dac_clk_in, fb_en, store_strb,
               gain, offset, out_lim,
        output dac_data, dac_wr, sat_flag, oflow_count
    );
endinterface
`default_nettype wire

// File: rtl/fb_dac_driver_scale_clamp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_scale_clamp : gain shift, offset add and symmetric clamp (comb.)      |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module fb_scale_clamp #(
    parameter int DAC_W     = fb_dac_pkg::DAC_W,
    parameter int GAIN_FRAC = fb_dac_pkg::GAIN_FRAC
) (
    input  logic signed [fb_dac_pkg::PROD_W-1:0] prod_i,
    input  logic signed [DAC_W-1:0]              offset_i,
    input  logic        [DAC_W-2:0]              lim_i,
    output logic signed [DAC_W-1:0]              data_o,
    output logic                                 sat_o
);
    import fb_dac_pkg::*;

    logic signed [SUM_W-1:0] sum_w;
    logic signed [SUM_W-1:0] lim_pos_w;
    logic signed [SUM_W-1:0] lim_neg_w;

    // Arithmetic shift truncates toward -inf; the sum cannot overflow 19 bits.
    assign sum_w     = SUM_W'(prod_i >>> GAIN_FRAC) + SUM_W'(offset_i);
    assign lim_pos_w = SUM_W'({1'b0, lim_i});
    assign lim_neg_w = -lim_pos_w;

    always_comb begin
        data_o = sum_w[DAC_W-1:0];
        sat_o  = 1'b0;
        if (sum_w > lim_pos_w) begin
            data_o = lim_pos_w[DAC_W-1:0];
            sat_o  = 1'b1;
        end else if (sum_w < lim_neg_w) begin
            data_o = lim_neg_w[DAC_W-1:0];
            sat_o  = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fb_dac_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_dac_driver : two-sample average, gain/offset/clamp, kicker DAC write  |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module fb_dac_driver #(
    parameter int DAC_W     = fb_dac_pkg::DAC_W,
    parameter int GAIN_FRAC = fb_dac_pkg::GAIN_FRAC
) (
    input  logic           clk,
    input  logic           rst_n,
    fb_dac_driver_if.slave bus
);
    import fb_dac_pkg::*;

    state_e                  state_q,    state_d;
    logic signed [ACC_W-1:0] acc_q,      acc_d;
    logic signed [PROD_W-1:0] prod_q,    prod_d;
    logic                    bad_q,      bad_d;
    logic [DAC_W-1:0]        dac_data_q, dac_data_d;
    logic                    dac_wr_q,   dac_wr_d;
    logic                    sat_q,      sat_d;
    logic [7:0]              cnt_q,      cnt_d;
    logic                    store_q;

    logic signed [DAC_W-1:0]  fb_val_w;
    logic signed [DAC_W-1:0]  zk_val_w;
    logic                     fb_sat_w;
    logic                     zk_sat_w;
    logic signed [PROD_W-1:0] acc_x_w;
    logic signed [PROD_W-1:0] gain_x_w;
    logic                     store_rise_w;
    logic                     store_fall_w;

    assign acc_x_w      = PROD_W'(acc_q);
    assign gain_x_w     = PROD_W'({1'b0, bus.gain});
    assign store_rise_w =  bus.store_strb & ~store_q;
    assign store_fall_w = ~bus.store_strb &  store_q;

    fb_scale_clamp #(.DAC_W(DAC_W), .GAIN_FRAC(GAIN_FRAC)) u_fb_path (
        .prod_i   (prod_q),
        .offset_i (bus.offset),
        .lim_i    (bus.out_lim),
        .data_o   (fb_val_w),
        .sat_o    (fb_sat_w)
    );

    // Zero-kick level: same clamp applied to the bare offset.
    fb_scale_clamp #(.DAC_W(DAC_W), .GAIN_FRAC(GAIN_FRAC)) u_zk_path (
        .prod_i   ('0),
        .offset_i (bus.offset),
        .lim_i    (bus.out_lim),
        .data_o   (zk_val_w),
        .sat_o    (zk_sat_w)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        prod_d     = prod_q;
        bad_d      = bad_q;
        dac_data_d = dac_data_q;
        sat_d      = sat_q;
        cnt_d      = cnt_q;
        dac_wr_d   = bus.dac_clk_in & bus.fb_en;

        case (state_q)
            ST_IDLE: begin
                if (bus.fb_cond) begin
                    acc_d   = ACC_W'(bus.pout);
                    bad_d   = bus.dsp_oflow;
                    state_d = ST_ACC1;
                end
                if (bus.dac_clk_in) begin
                    dac_data_d = to_offset_binary(zk_val_w);
                    sat_d      = sat_q | zk_sat_w;
                end
            end
            ST_ACC1: begin
                if (bus.fb_cond) begin
                    acc_d = acc_q + ACC_W'(bus.pout);
                    bad_d = bad_q | bus.dsp_oflow;
                end else begin
                    acc_d = acc_q <<< 1;
                end
                state_d = ST_SCALE;
            end
            ST_SCALE: begin
                prod_d  = acc_x_w * gain_x_w;
                state_d = ST_READY;
            end
            ST_READY: begin
                if (bus.dac_clk_in) begin
                    if (bad_q) begin
                        if (cnt_q != 8'hFF) begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        dac_data_d = to_offset_binary(fb_val_w);
                        sat_d      = sat_q | fb_sat_w;
                    end
                    state_d = ST_WRITE;
                end else if (store_fall_w) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (!bus.dac_clk_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (store_rise_w) begin
            sat_d = 1'b0;
            cnt_d = 8'd0;
        end

        if (!bus.fb_en) begin
            state_d    = ST_IDLE;
            dac_data_d = to_offset_binary(zk_val_w);
            sat_d      = (store_rise_w ? 1'b0 : sat_q) | zk_sat_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            prod_q     <= '0;
            bad_q      <= 1'b0;
            dac_data_q <= DAC_MID;
            dac_wr_q   <= 1'b0;
            sat_q      <= 1'b0;
            cnt_q      <= 8'd0;
            store_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            prod_q     <= prod_d;
            bad_q      <= bad_d;
            dac_data_q <= dac_data_d;
            dac_wr_q   <= dac_wr_d;
            sat_q      <= sat_d;
            cnt_q      <= cnt_d;
            store_q    <= bus.store_strb;
        end
    end

    assign bus.dac_data    = dac_data_q;
    assign bus.dac_wr      = dac_wr_q & bus.fb_en;
    assign bus.sat_flag    = sat_q;
    assign bus.oflow_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_dac_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fb_dac_driver : directed vector bench for fb_dac_driver               |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module tb_fb_dac_driver;

    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_bad   = 0;
    int   cur_data;

    always #5 clk = ~clk;

    fb_dac_driver_if #(.DAC_W(14)) bus ();

    fb_dac_driver #(.DAC_W(14), .GAIN_FRAC(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit                 clr;
        logic signed [14:0] p0;
        logic signed [14:0] p1;
        bit                 two;
        bit                 of0;
        bit                 of1;
        logic [7:0]         gain;
        logic signed [13:0] offset;
        logic [12:0]        lim;
        int                 exp_data;
        int                 exp_sat;
        int                 exp_cnt;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input bit clr, input int p0, input int p1, input bit two,
                                input bit of0, input bit of1, input int g, input int off,
                                input int lim, input int dat, input int s, input int c);
        vec_t v;
        v.clr = clr; v.p0 = 15'(p0); v.p1 = 15'(p1); v.two = two;
        v.of0 = of0; v.of1 = of1; v.gain = 8'(g); v.offset = 14'(off);
        v.lim = 13'(lim); v.exp_data = dat; v.exp_sat = s; v.exp_cnt = c;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.fb_cond = 1'b0; bus.dac_clk_in = 1'b0; bus.pout = '0;
        bus.dsp_oflow = 1'b0; bus.store_strb = 1'b0;
    endtask

    // Nominal window: fb_cond t0..t1, SCALE t2, dac_clk_in t3..t4.
    task automatic run_window(input vec_t v, input string tag);
        bus.fb_en = 1'b1;
        if (v.clr) begin
            bus.store_strb = 1'b1; tick();
            bus.store_strb = 1'b0; tick();
        end
        bus.gain = v.gain; bus.offset = v.offset; bus.out_lim = v.lim;
        bus.fb_cond = 1'b1; bus.pout = v.p0; bus.dsp_oflow = v.of0; tick();
        bus.fb_cond = v.two; bus.pout = v.p1; bus.dsp_oflow = v.of1; tick();
        bus.fb_cond = 1'b0; bus.pout = '0; bus.dsp_oflow = 1'b0; tick();
        bus.dac_clk_in = 1'b1;
        chk({tag, "_hold"}, int'(bus.dac_data), cur_data);
        chk({tag, "_wr_t3"}, int'(bus.dac_wr), 0);
        tick();
        chk({tag, "_data"}, int'(bus.dac_data), v.exp_data);
        chk({tag, "_wr_t4"}, int'(bus.dac_wr), 1);
        tick();
        bus.dac_clk_in = 1'b0;
        chk({tag, "_wr_t5"}, int'(bus.dac_wr), 1);
        tick();
        chk({tag, "_wr_t6"}, int'(bus.dac_wr), 0);
        chk({tag, "_sat"}, int'(bus.sat_flag), v.exp_sat);
        chk({tag, "_cnt"}, int'(bus.oflow_count), v.exp_cnt);
        cur_data = v.exp_data;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(1,   1000,   1000, 1, 0, 0,  64,    0, 8191, 10192, 0, 0);
        vecs[1]  = mk(0,   -500,   -500, 1, 0, 0,  32,    0, 8191,  7692, 0, 0);
        vecs[2]  = mk(0,  16000,  16000, 1, 0, 0, 255,    0, 4000, 12192, 1, 0);
        vecs[3]  = mk(0,    100,    100, 1, 0, 0,  64, -300, 8191,  8092, 1, 0);
        vecs[4]  = mk(1,     -1,     -2, 1, 0, 0,   1,    0, 8191,  8191, 0, 0);
        vecs[5]  = mk(0,      1,      2, 1, 0, 0,   1,    0, 8191,  8192, 0, 0);
        vecs[6]  = mk(0,   1000,   1000, 1, 0, 0,  96,    0, 8191, 11192, 0, 0);
        vecs[7]  = mk(0,   2000,   2000, 1, 0, 0,  64,    0, 4000, 12192, 0, 0);
        vecs[8]  = mk(0,   2000,   2001, 1, 0, 0,  64,    0, 4000, 12192, 1, 0);
        vecs[9]  = mk(1, -16000, -16000, 1, 0, 0, 255,    0, 4000,  4192, 1, 0);
        vecs[10] = mk(1,    300,      0, 0, 0, 0,  64,    0, 8191,  8792, 0, 0);
        vecs[11] = mk(0,    500,    500, 1, 0, 1,  64,    0, 8191,  8792, 0, 1);
        vecs[12] = mk(0,      0,      0, 1, 0, 0,  64, 5000, 4000, 12192, 1, 1);
        vecs[13] = mk(1,     10,     10, 1, 1, 0,  64,    0, 8191, 12192, 0, 1);

        rst_n = 1'b0;
        idle_inputs();
        bus.fb_en = 1'b1; bus.gain = 8'd64; bus.offset = '0; bus.out_lim = 13'd8191;
        tick(); tick();
        chk("rst_data", int'(bus.dac_data), 16'h2000);
        chk("rst_wr",   int'(bus.dac_wr), 0);
        chk("rst_sat",  int'(bus.sat_flag), 0);
        chk("rst_cnt",  int'(bus.oflow_count), 0);
        rst_n = 1'b1;
        cur_data = 16'h2000;
        tick();

        for (int i = 0; i < 14; i++) begin
            run_window(vecs[i], $sformatf("v%0d", i));
        end

        // Saturating overflow counter: already at 1, push well past 255.
        for (int i = 0; i < 300; i++) begin
            run_window(mk(0, 100, 100, 1, 0, 1, 64, 0, 8191, cur_data, 0,
                          (i + 2 > 255) ? 255 : i + 2), $sformatf("of%0d", i));
        end
        run_window(mk(0, 16000, 16000, 1, 0, 0, 255, 0, 4000, 12192, 1, 255), "presat");

        // Asynchronous reset while in SCALE.
        bus.gain = 8'd64; bus.offset = '0; bus.out_lim = 13'd8191;
        bus.fb_cond = 1'b1; bus.pout = 15'sd1000; tick(); tick();
        bus.fb_cond = 1'b0; bus.pout = '0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", int'(bus.dac_data), 16'h2000);
        chk("mid_rst_wr",   int'(bus.dac_wr), 0);
        chk("mid_rst_sat",  int'(bus.sat_flag), 0);
        chk("mid_rst_cnt",  int'(bus.oflow_count), 0);
        tick(); tick();
        rst_n = 1'b1;
        cur_data = 16'h2000;
        tick();
        run_window(vecs[0], "post_rst");

        // READY held without dac_clk_in; a second window must be ignored.
        bus.fb_cond = 1'b1; bus.pout = 15'sd2000; tick(); tick();
        bus.fb_cond = 1'b0; bus.pout = '0;
        repeat (4) tick();
        bus.fb_cond = 1'b1; bus.pout = -15'sd500; tick(); tick();
        bus.fb_cond = 1'b0; bus.pout = '0;
        repeat (3) tick();
        chk("hold_nowrite", int'(bus.dac_data), 10192);
        bus.dac_clk_in = 1'b1; tick();
        chk("hold_data", int'(bus.dac_data), 12192);
        tick();
        bus.dac_clk_in = 1'b0; tick(); tick();

        // Store strobe falling edge releases a stuck READY; bare pulse gives zero-kick.
        bus.fb_cond = 1'b1; bus.pout = 15'sd300; tick();
        bus.fb_cond = 1'b0; bus.pout = '0; tick(); tick(); tick();
        bus.store_strb = 1'b1; tick();
        bus.store_strb = 1'b0; tick(); tick();
        bus.offset = 14'sd100;
        bus.dac_clk_in = 1'b1; tick();
        chk("zk_data", int'(bus.dac_data), 8292);
        tick();
        chk("zk_wr", int'(bus.dac_wr), 1);
        bus.dac_clk_in = 1'b0; tick(); tick();

        // Feedback disable: dac_wr gated at once, DAC held at zero-kick, FSM idle.
        bus.offset = 14'sd200;
        bus.dac_clk_in = 1'b1; tick();
        chk("en_bare", int'(bus.dac_data), 8392);
        chk("en_wr_on", int'(bus.dac_wr), 1);
        bus.fb_en = 1'b0;
        #1;
        chk("en_wr_gate", int'(bus.dac_wr), 0);
        bus.offset = 14'sd5000; bus.out_lim = 13'd4000;
        bus.fb_cond = 1'b1; bus.pout = 15'sd1000; tick(); tick();
        chk("en_zk_clamp", int'(bus.dac_data), 12192);
        chk("en_wr_off", int'(bus.dac_wr), 0);
        bus.dac_clk_in = 1'b0; bus.fb_cond = 1'b0; bus.pout = '0; tick();
        bus.fb_en = 1'b1; bus.offset = '0; bus.out_lim = 13'd8191;
        repeat (4) tick();
        chk("en_nohold", int'(bus.dac_data), 12192);
        bus.dac_clk_in = 1'b1; tick();
        chk("en_idle", int'(bus.dac_data), 8192);
        bus.dac_clk_in = 1'b0; tick(); tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
